tfhe_pu_led_status: RTL

- Parametrised status-LED controller for the TFHE PU top level. Drives the board LED bank from one registered output bus.
- leds[0] is a heartbeat. The other LEDs are pulse-stretched activity indicators, one per channel (PCIe, DMA, bootstrap core, and so on).
- A sticky error flag overrides normal display with a fast blink. Mode input supports all-off and lamp-test.
- Sits between the block-design status nets and the top-level leds pins.

---
 rtl/tfhe_pu_led_status.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/tfhe_pu_led_status.sv
// -----------------------------------------------------------------------------
// tfhe_pu_led_status
//
// Status-LED controller for the TFHE PU top level. leds[0] is a heartbeat;
// leds[NUM_LEDS-1:1] are pulse-stretched activity indicators, one per
// channel. A sticky error flag replaces the normal display with a fast blink
// (4x the heartbeat rate, phase-aligned with it). The mode input selects
// normal display, all-off, lamp-test or a forced error blink. All counters
// keep running in every mode, so a mode change never restarts anything.
//
// Optional build macro:
//   LED_PWM_EN - adds the 8-bit duty input and a free-running PWM counter
//                that dims the normal and error displays. Without it the
//                display runs at full brightness.
//
// Ports:
//   clk        in   1           system clock
//   rstn       in   1           asynchronous active-low reset
//   act_pulse  in   NUM_LEDS-1  per-channel activity strobe (clk domain)
//   mode       in   2           00 normal, 01 all-off, 10 lamp-test,
//                               11 forced error blink
//   err_set    in   1           set sticky error flag (wins over clear)
//   err_clr    in   1           clear sticky error flag
//   duty       in   8           PWM brightness (LED_PWM_EN builds only)
//   err_flag   out  1           sticky error flag, registered
//   leds       out  NUM_LEDS    LED drive, registered
// -----------------------------------------------------------------------------
module tfhe_pu_led_status #(
   parameter int NUM_LEDS       = 8,
   parameter int CLK_HZ         = 100000000,
   parameter int HEARTBEAT_HZ   = 1,
   parameter int STRETCH_CYCLES = 5000000
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NUM_LEDS-2:0] act_pulse,
   input  logic [1:0]          mode,
   input  logic                err_set,
   input  logic                err_clr,
`ifdef LED_PWM_EN
   input  logic [7:0]          duty,
`endif
   output logic                err_flag,
   output logic [NUM_LEDS-1:0] leds
);

   localparam int NCH     = NUM_LEDS - 1;
   localparam int HB_HALF = CLK_HZ / (2 * HEARTBEAT_HZ);
   localparam int FB_Q    = HB_HALF / 4;
   localparam int HB_W    = $clog2(HB_HALF);
   localparam int FB_W    = (FB_Q > 1) ? $clog2(FB_Q) : 1;
   localparam int CNT_W   = (STRETCH_CYCLES > 1) ? $clog2(STRETCH_CYCLES + 1) : 1;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_OFF    = 2'b01;
   localparam logic [1:0] MODE_LAMP   = 2'b10;

   // Parameter sanity checks, reported at elaboration time.
   generate
      if (NUM_LEDS < 2 || NUM_LEDS > 32) begin : g_bad_num_leds
         $error("tfhe_pu_led_status: NUM_LEDS must be in 2..32");
      end
      if (STRETCH_CYCLES < 1) begin : g_bad_stretch
         $error("tfhe_pu_led_status: STRETCH_CYCLES must be >= 1");
      end
      if (HB_HALF < 4 || (HB_HALF % 4) != 0) begin : g_bad_hb_half
         $error("tfhe_pu_led_status: CLK_HZ/(2*HEARTBEAT_HZ) must be >= 4 and a multiple of 4");
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Heartbeat and fast blink.
   // The fast-blink counter divides by HB_HALF/4 instead of taking a modulo of
   // the heartbeat counter. Because HB_HALF is a multiple of HB_HALF/4 and
   // both counters reset together, they stay phase-aligned forever.
   // -------------------------------------------------------------------------
   logic [HB_W-1:0] r_hb_cnt;
   logic [FB_W-1:0] r_fb_cnt;
   logic            r_hb;
   logic            r_fb;
   logic            w_hb_wrap;
   logic            w_fb_wrap;
   logic [HB_W-1:0] w_hb_cnt_next;
   logic [FB_W-1:0] w_fb_cnt_next;
   logic            w_hb_next;
   logic            w_fb_next;

   assign w_hb_wrap     = (r_hb_cnt == HB_W'(HB_HALF - 1));
   assign w_fb_wrap     = (r_fb_cnt == FB_W'(FB_Q - 1));
   assign w_hb_cnt_next = w_hb_wrap ? '0 : r_hb_cnt + 1'b1;
   assign w_fb_cnt_next = w_fb_wrap ? '0 : r_fb_cnt + 1'b1;
   assign w_hb_next     = r_hb ^ w_hb_wrap;
   assign w_fb_next     = r_fb ^ w_fb_wrap;

   // -------------------------------------------------------------------------
   // Activity pulse stretchers. A strobe reloads the full count (so a
   // retrigger only ever extends the lit time); otherwise count down and hold
   // at zero. The LED is lit from the loading edge while the next count is
   // nonzero, giving exactly STRETCH_CYCLES lit cycles for an isolated pulse.
   // -------------------------------------------------------------------------
   logic [NCH-1:0] w_act;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_chan
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_cnt_next;

         always_comb begin
            w_cnt_next = r_cnt;
            if (act_pulse[gi]) begin
               w_cnt_next = CNT_W'(STRETCH_CYCLES);
            end else if (r_cnt != '0) begin
               w_cnt_next = r_cnt - 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_next;
            end
         end

         assign w_act[gi] = (w_cnt_next != '0);
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Sticky error flag: set has priority over clear.
   // -------------------------------------------------------------------------
   logic r_err;
   logic w_err_next;

   assign w_err_next = err_set ? 1'b1 : (err_clr ? 1'b0 : r_err);

   // -------------------------------------------------------------------------
   // Brightness gate. Only the normal and error displays are dimmed; lamp-test
   // and all-off are absolute.
   // -------------------------------------------------------------------------
   logic w_gate;

`ifdef LED_PWM_EN
   logic [7:0] r_pwm_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + 8'd1;
      end
   end

   assign w_gate = (duty == 8'hFF) | (r_pwm_cnt < duty);
`else
   assign w_gate = 1'b1;
`endif

   // -------------------------------------------------------------------------
   // Display select, computed from next-state values so the registered LEDs
   // line up with the state registers on the same edge.
   // -------------------------------------------------------------------------
   logic [NUM_LEDS-1:0] w_leds_next;

   always_comb begin
      w_leds_next = '0;
      if (mode == MODE_OFF) begin
         w_leds_next = '0;
      end else if (mode == MODE_LAMP) begin
         w_leds_next = '1;
      end else if (mode != MODE_NORMAL || w_err_next) begin
         w_leds_next = {NUM_LEDS{w_fb_next & w_gate}};
      end else begin
         w_leds_next = {w_act, w_hb_next} & {NUM_LEDS{w_gate}};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_hb_cnt <= '0;
         r_fb_cnt <= '0;
         r_hb     <= 1'b0;
         r_fb     <= 1'b0;
         r_err    <= 1'b0;
         leds     <= '0;
      end else begin
         r_hb_cnt <= w_hb_cnt_next;
         r_fb_cnt <= w_fb_cnt_next;
         r_hb     <= w_hb_next;
         r_fb     <= w_fb_next;
         r_err    <= w_err_next;
         leds     <= w_leds_next;
      end
   end

   assign err_flag = r_err;

endmodule
